// File: rtl/gcd_job_arbiter.sv
// Round-robin arbiter that shares one GCD engine between NUM_REQ requesters,
// one job in flight at a time. Optional zero-operand bypass: GCD_ARB_ZERO_BYPASS_EN.
module gcd_job_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   input  logic [NUM_REQ-1:0]       resp_ready_i,
   output logic [WIDTH-1:0]         resp_data_o,
   output logic                     core_start_o,
   output logic [WIDTH-1:0]         core_a_o,
   output logic [WIDTH-1:0]         core_b_o,
   input  logic                     core_done_i,
   input  logic [WIDTH-1:0]         core_result_i,
   output logic                     busy_o,
   output logic [IDW-1:0]           grant_id_o
);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;

   state_e           state_q;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             start_q;

   logic [WIDTH-1:0] a_arr [NUM_REQ];
   logic [WIDTH-1:0] b_arr [NUM_REQ];
   logic             sel_found;
   logic [IDW-1:0]   sel_id;
   logic [IDW:0]     scan_sum;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [IDW-1:0]   rr_next;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a_i[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b_i[g*WIDTH +: WIDTH];
   end

   // Scan from rr_ptr upward, wrapping modulo NUM_REQ; the first valid requester wins.
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      scan_sum  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (scan_sum >= (IDW+1)'(NUM_REQ)) scan_sum = scan_sum - (IDW+1)'(NUM_REQ);
         if (!sel_found && req_valid_i[scan_sum[IDW-1:0]]) begin
            sel_found = 1'b1;
            sel_id    = scan_sum[IDW-1:0];
         end
      end
   end

   assign sel_a   = a_arr[sel_id];
   assign sel_b   = b_arr[sel_id];
   assign rr_next = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + IDW'(1);

   always_comb begin
      req_ready_o = '0;
      if (state_q == S_IDLE && sel_found) req_ready_o[sel_id] = 1'b1;
   end

   always_comb begin
      resp_valid_o = '0;
      if (state_q == S_RESP) resp_valid_o[id_q] = 1'b1;
   end

   assign busy_o       = (state_q != S_IDLE);
   assign grant_id_o   = busy_o ? id_q : '0;
   assign core_a_o     = a_q;
   assign core_b_o     = b_q;
   assign resp_data_o  = res_q;
   assign core_start_o = start_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         start_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sel_found) begin
                  a_q  <= sel_a;
                  b_q  <= sel_b;
                  id_q <= sel_id;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                  // GCD(x,0) = x, so a zero operand is answered without the engine.
                  if (sel_a == '0 || sel_b == '0) begin
                     res_q   <= sel_a | sel_b;
                     state_q <= S_RESP;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= S_LAUNCH;
                  end
`else
                  start_q <= 1'b1;
                  state_q <= S_LAUNCH;
`endif
               end
            end
            S_LAUNCH: state_q <= S_WAIT;
            S_WAIT: begin
               if (core_done_i) begin
                  res_q   <= core_result_i;
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready_i[id_q]) begin
                  rr_ptr_q <= rr_next;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed, table-driven bench for gcd_job_arbiter; the engine is emulated by
// driving core_done_i/core_result_i with hand-computed GCD values.
module tb_gcd_job_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 16;
   localparam int IDW     = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid_i;
   logic [NUM_REQ*WIDTH-1:0] req_a_i;
   logic [NUM_REQ*WIDTH-1:0] req_b_i;
   logic [NUM_REQ-1:0]       req_ready_o;
   logic [NUM_REQ-1:0]       resp_valid_o;
   logic [NUM_REQ-1:0]       resp_ready_i;
   logic [WIDTH-1:0]         resp_data_o;
   logic                     core_start_o;
   logic [WIDTH-1:0]         core_a_o;
   logic [WIDTH-1:0]         core_b_o;
   logic                     core_done_i;
   logic [WIDTH-1:0]         core_result_i;
   logic                     busy_o;
   logic [IDW-1:0]           grant_id_o;

   logic [WIDTH-1:0] op_a [NUM_REQ];
   logic [WIDTH-1:0] op_b [NUM_REQ];

   always #5 clk = ~clk;

   always_comb begin
      req_a_i = '0;
      req_b_i = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         req_a_i[r*WIDTH +: WIDTH] = op_a[r];
         req_b_i[r*WIDTH +: WIDTH] = op_b[r];
      end
   end

   gcd_job_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_ready_o  (req_ready_o),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .core_start_o (core_start_o),
      .core_a_o     (core_a_o),
      .core_b_o     (core_b_o),
      .core_done_i  (core_done_i),
      .core_result_i(core_result_i),
      .busy_o       (busy_o),
      .grant_id_o   (grant_id_o)
   );

   typedef struct {
      logic [NUM_REQ-1:0] valid;
      int                 exp_id;
      logic [WIDTH-1:0]   exp_res;
      int                 k;
      int                 hold;
   } vec_t;

   vec_t tbl [10];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept at t, start at t+1, done at t+k, response at t+k+1, held `hold` cycles.
   task automatic run_job(input int j, input logic [NUM_REQ-1:0] valid, input int id,
                          input logic [WIDTH-1:0] res, input int k, input int hold);
      logic [NUM_REQ-1:0] onehot;
      onehot      = NUM_REQ'(1) << id;
      req_valid_i = valid;
      #1;
      check($sformatf("job%0d accept ready", j), 64'(req_ready_o), 64'(onehot));
      check($sformatf("job%0d idle busy", j), 64'(busy_o), 64'(0));
      step();
      check($sformatf("job%0d start", j), 64'(core_start_o), 64'(1));
      check($sformatf("job%0d grant", j), 64'(grant_id_o), 64'(id));
      check($sformatf("job%0d core_a", j), 64'(core_a_o), 64'(op_a[id]));
      check($sformatf("job%0d core_b", j), 64'(core_b_o), 64'(op_b[id]));
      check($sformatf("job%0d launch ready", j), 64'(req_ready_o), 64'(0));
      for (int c = 2; c <= k; c++) begin
         step();
         check($sformatf("job%0d wait start", j), 64'(core_start_o), 64'(0));
         check($sformatf("job%0d wait resp", j), 64'(resp_valid_o), 64'(0));
         if (c == k) begin
            core_done_i   = 1'b1;
            core_result_i = res;
         end
      end
      step();
      core_done_i   = 1'b0;
      core_result_i = '0;
      check($sformatf("job%0d resp_valid", j), 64'(resp_valid_o), 64'(onehot));
      check($sformatf("job%0d resp_data", j), 64'(resp_data_o), 64'(res));
      check($sformatf("job%0d resp busy", j), 64'(busy_o), 64'(1));
      for (int h = 0; h < hold; h++) begin
         resp_ready_i = ~onehot;
         step();
         check($sformatf("job%0d hold valid", j), 64'(resp_valid_o), 64'(onehot));
         check($sformatf("job%0d hold data", j), 64'(resp_data_o), 64'(res));
         check($sformatf("job%0d hold ready", j), 64'(req_ready_o), 64'(0));
      end
      resp_ready_i = onehot;
      step();
      resp_ready_i = '0;
      check($sformatf("job%0d back idle", j), 64'(busy_o), 64'(0));
      check($sformatf("job%0d resp cleared", j), 64'(resp_valid_o), 64'(0));
   endtask

   initial begin
      rst           = 1'b1;
      req_valid_i   = '0;
      resp_ready_i  = '0;
      core_done_i   = 1'b0;
      core_result_i = '0;
      op_a[0] = 16'd48;  op_b[0] = 16'd18;
      op_a[1] = 16'd35;  op_b[1] = 16'd21;
      op_a[2] = 16'd100; op_b[2] = 16'd75;
      op_a[3] = 16'd81;  op_b[3] = 16'd27;

      // Round-robin pointer after each entry is (exp_id + 1) mod 4.
      tbl[0] = '{4'b0001, 0, 16'd6,  6, 0};
      tbl[1] = '{4'b1111, 1, 16'd7,  3, 0};
      tbl[2] = '{4'b1111, 2, 16'd25, 2, 10};
      tbl[3] = '{4'b1111, 3, 16'd27, 4, 0};
      tbl[4] = '{4'b1111, 0, 16'd6,  2, 0};
      tbl[5] = '{4'b0001, 0, 16'd6,  3, 0};
      tbl[6] = '{4'b1000, 3, 16'd27, 2, 0};
      tbl[7] = '{4'b0110, 1, 16'd7,  2, 0};
      tbl[8] = '{4'b0110, 2, 16'd25, 3, 1};
      tbl[9] = '{4'b0011, 0, 16'd6,  2, 0};

      step();
      step();
      rst = 1'b0;
      check("reset busy", 64'(busy_o), 64'(0));
      check("reset grant", 64'(grant_id_o), 64'(0));
      check("reset start", 64'(core_start_o), 64'(0));
      check("reset core_a", 64'(core_a_o), 64'(0));
      check("reset core_b", 64'(core_b_o), 64'(0));
      check("reset resp_valid", 64'(resp_valid_o), 64'(0));
      check("reset resp_data", 64'(resp_data_o), 64'(0));
      check("reset req_ready", 64'(req_ready_o), 64'(0));

      for (int j = 0; j < 10; j++)
         run_job(j, tbl[j].valid, tbl[j].exp_id, tbl[j].exp_res, tbl[j].k, tbl[j].hold);

      // Spurious done in IDLE, LAUNCH and RESP; pointer is 1, so requester 2 wins.
      req_valid_i   = '0;
      core_done_i   = 1'b1;
      core_result_i = 16'd99;
      step();
      core_done_i = 1'b0;
      check("idle done busy", 64'(busy_o), 64'(0));
      check("idle done resp", 64'(resp_valid_o), 64'(0));
      req_valid_i = 4'b0100;
      #1;
      check("spur accept", 64'(req_ready_o), 64'(4'b0100));
      step();
      check("spur start", 64'(core_start_o), 64'(1));
      core_done_i   = 1'b1;
      core_result_i = 16'd77;
      step();
      core_done_i = 1'b0;
      req_valid_i = '0;
      check("spur launch done ignored", 64'(resp_valid_o), 64'(0));
      step();
      check("spur still waiting", 64'(resp_valid_o), 64'(0));
      check("spur busy", 64'(busy_o), 64'(1));
      core_done_i   = 1'b1;
      core_result_i = 16'd25;
      step();
      core_done_i = 1'b0;
      check("spur resp_valid", 64'(resp_valid_o), 64'(4'b0100));
      check("spur resp_data", 64'(resp_data_o), 64'(25));
      core_done_i   = 1'b1;
      core_result_i = 16'd55;
      step();
      core_done_i = 1'b0;
      check("resp done ignored", 64'(resp_data_o), 64'(25));
      resp_ready_i = 4'b0100;
      step();
      resp_ready_i = '0;
      check("spur back idle", 64'(busy_o), 64'(0));

      // Reset while in WAIT; pointer is 3 so requester 1 is reached after wrapping.
      req_valid_i = 4'b0010;
      #1;
      check("rstjob accept", 64'(req_ready_o), 64'(4'b0010));
      step();
      req_valid_i = '0;
      step();
      check("rstjob waiting", 64'(busy_o), 64'(1));
      check("rstjob grant", 64'(grant_id_o), 64'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst busy", 64'(busy_o), 64'(0));
      check("midrst grant", 64'(grant_id_o), 64'(0));
      check("midrst core_a", 64'(core_a_o), 64'(0));
      check("midrst core_b", 64'(core_b_o), 64'(0));
      check("midrst resp_valid", 64'(resp_valid_o), 64'(0));
      check("midrst resp_data", 64'(resp_data_o), 64'(0));
      core_done_i   = 1'b1;
      core_result_i = 16'd123;
      step();
      core_done_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         check("midrst no stale resp", 64'(resp_valid_o), 64'(0));
      end
      // A pointer left at 3 would grant requester 3 here.
      run_job(20, 4'b1010, 1, 16'd7, 3, 0);

      // Zero operand on requester 0; pointer is 2.
      op_a[0] = 16'd0;
      op_b[0] = 16'd42;
`ifdef GCD_ARB_ZERO_BYPASS_EN
      req_valid_i = 4'b0001;
      #1;
      check("zero accept", 64'(req_ready_o), 64'(4'b0001));
      step();
      req_valid_i = '0;
      check("zero no start", 64'(core_start_o), 64'(0));
      check("zero resp_valid", 64'(resp_valid_o), 64'(4'b0001));
      check("zero resp_data", 64'(resp_data_o), 64'(42));
      resp_ready_i = 4'b0001;
      step();
      resp_ready_i = '0;
      check("zero back idle", 64'(busy_o), 64'(0));
`else
      run_job(30, 4'b0001, 0, 16'd42, 3, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/gcd_job_arbiter.md
Name: gcd_job_arbiter

Overview:
- Shares one GCD engine (controller + modulo ALU datapath) between NUM_REQ independent requesters.
- Accepts one job per requester with round-robin fairness and latches its operands.
- Drives the engine's start pulse and waits for the engine's done flag.
- Returns the result to the originating requester over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..8.
- WIDTH, 16, operand and result width in bits.
- IDW, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester job request.
- req_a_i  in  NUM_REQ*WIDTH  operand A; requester r uses bits [r*WIDTH +: WIDTH].
- req_b_i  in  NUM_REQ*WIDTH  operand B, same packing as req_a_i.
- req_ready_o  out  NUM_REQ  one-hot job-accept strobe.
- resp_valid_o  out  NUM_REQ  one-hot result valid.
- resp_ready_i  in  NUM_REQ  per-requester result accept.
- resp_data_o  out  WIDTH  result; meaningful only while resp_valid_o is nonzero.
- core_start_o  out  1  one-cycle start pulse to the GCD engine.
- core_a_o  out  WIDTH  operand A to the engine; held stable for the whole job.
- core_b_o  out  WIDTH  operand B to the engine; held stable for the whole job.
- core_done_i  in  1  engine result-valid pulse.
- core_result_i  in  WIDTH  engine result.
- busy_o  out  1  high in every state except IDLE.
- grant_id_o  out  IDW  index of the job currently owned.

Behaviour:
- Reset values:
  - State IDLE; rr_ptr = 0.
  - All outputs 0; operand, result and id registers cleared.
- States:
  - IDLE: scan req_valid_i starting at rr_ptr, wrapping modulo NUM_REQ. For the first set bit r:
    - assert req_ready_o[r] combinationally this cycle (handshake completes);
    - latch operands into a_r/b_r and r into id_r;
    - go to LAUNCH.
    - If no bit is set, stay in IDLE.
  - LAUNCH: core_start_o = 1 for exactly this cycle; go to WAIT. Any core_done_i seen in this cycle is ignored.
  - WAIT: hold core_a_o/core_b_o. On core_done_i = 1, capture core_result_i into res_r and go to RESP.
  - RESP:
    - resp_valid_o[id_r] = 1 and resp_data_o = res_r, held until resp_ready_i[id_r] = 1.
    - On that cycle: rr_ptr <= (id_r + 1) mod NUM_REQ, then go to IDLE.
    - resp_ready_i bits of other requesters are ignored.
- Timing:
  - Latency: accept at cycle t, start pulse at t+1, done at t+k (k >= 2), resp_valid at t+k+1.
  - The earliest next accept is the cycle after the response handshake. No overlap of jobs.
- Handshake rules:
  - Only one job is in flight.
  - req_ready_o is never asserted outside IDLE and is at most one-hot.
  - A requester may drop req_valid_i before acceptance; nothing is recorded.
  - Operands are sampled only in the accept cycle.
- Outputs:
  - grant_id_o = id_r in every non-IDLE state; 0 in IDLE.
  - core_a_o/core_b_o = a_r/b_r at all times.
- Fairness: a requester that holds valid is served within NUM_REQ jobs.
- Simultaneous events:
  - If requests arrive in the same cycle a response handshake completes, they are considered next cycle with the updated rr_ptr.
  - A core_done_i arriving while in IDLE or RESP is ignored.
- Reset mid-operation: the job is abandoned and no response is issued. The engine shares rst and restarts clean.
- Operand order: the engine orders operands itself; the arbiter passes A/B unchanged.

Optional Feature:
- Macro: GCD_ARB_ZERO_BYPASS_EN.
- When defined:
  - In the IDLE accept, if the selected A == 0 or B == 0, skip LAUNCH/WAIT.
  - res_r <= A | B (GCD(x,0) = x; both zero gives 0); next state is RESP directly; core_start_o stays 0.
  - Response appears the cycle after accept.
- When undefined: every job goes through the engine unchanged.

Test Plan:
- Single job: req 0 with A=48, B=18; engine model returns 6 after 5 cycles -> req_ready_o=0001 at t; core_start_o at t+1; resp_valid_o=0001 with data 6 at t+7.
- Round-robin: all four requesters hold valid, distinct operands -> grants in order 0,1,2,3,0; each response routed to the correct index with the correct GCD (e.g. 35,21 -> 7).
- Response backpressure: resp_ready_i[2] held low 10 cycles -> resp_valid_o[2] and resp_data_o stable; no new req_ready_o until release.
- Reset in WAIT: rst pulsed one cycle mid-job -> all outputs 0 next cycle; state IDLE; rr_ptr 0; no stale response afterwards.
- Spurious done: core_done_i pulsed in the LAUNCH cycle and in IDLE -> ignored; the real done later yields the correct result.
- Zero operand (A=0, B=42): with GCD_ARB_ZERO_BYPASS_EN, response 42 one cycle after accept and no core_start_o; without the macro, the engine is started and its returned value is forwarded.
